// File: rtl/unsigned_divider_16by8_seq.sv
// Sequential restoring unsigned divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per cycle, valid/ready handshake on both sides.
module unsigned_divider_16by8_seq #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] z,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] x,
  output logic [W-1:0]   r,
  output logic           div_by_zero
);

  localparam int unsigned ZW = 2 * W;
  localparam int unsigned CW = $clog2(ZW + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [W:0]    pr, pr_nx;
  logic [ZW-1:0] dvd, dvd_nx;
  logic [W-1:0]  y_q, y_nx;
  logic [ZW-1:0] x_nx;
  logic [W-1:0]  r_nx;
  logic          dbz_nx;
  logic          in_ready_nx, out_valid_nx;
  logic [W:0]    trial, diff;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pr          <= '0;
      dvd         <= '0;
      y_q         <= '0;
      x           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      pr          <= pr_nx;
      dvd         <= dvd_nx;
      y_q         <= y_nx;
      x           <= x_nx;
      r           <= r_nx;
      div_by_zero <= dbz_nx;
      in_ready    <= in_ready_nx;
      out_valid   <= out_valid_nx;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pr_nx    = pr;
    dvd_nx   = dvd;
    y_nx     = y_q;
    x_nx     = x;
    r_nx     = r;
    dbz_nx   = div_by_zero;
    trial    = {pr[W-1:0], dvd[ZW-1]};
    diff     = trial - {1'b0, y_q};

    case (state)
      IDLE: begin
        if (in_valid) begin
          dvd_nx   = z;
          y_nx     = y;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        if (y_q == '0) begin
          x_nx     = '1;
          r_nx     = dvd[W-1:0];
          dbz_nx   = 1'b1;
          state_nx = DONE;
        end else begin
          pr_nx    = '0;
          cnt_nx   = CW'(ZW);
          dbz_nx   = 1'b0;
          state_nx = RUN;
        end
      end
      RUN: begin
        dvd_nx = {dvd[ZW-2:0], 1'b0};
        // Partial remainder stays below y, so W+1 bits cannot overflow
        if (trial >= {1'b0, y_q}) begin
          pr_nx = diff;
          x_nx  = {x[ZW-2:0], 1'b1};
        end else begin
          pr_nx = trial;
          x_nx  = {x[ZW-2:0], 1'b0};
        end
        r_nx   = pr_nx[W-1:0];
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    in_ready_nx  = (state_nx == IDLE);
    out_valid_nx = (state_nx == DONE);
  end

endmodule

// File: tb/tb_unsigned_divider_16by8_seq.sv
// Directed and randomized self-checking bench for unsigned_divider_16by8_seq.
module tb_unsigned_divider_16by8_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [15:0] z, x;
  logic [7:0]  y, r;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  unsigned_divider_16by8_seq #(.W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .z(z), .y(y),
    .out_valid(out_valid), .out_ready(out_ready),
    .x(x), .r(r), .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One transaction: optional idle gap, accept, wait result, optional stall, consume
  task automatic do_div(input logic [15:0] zz, input logic [7:0] yy, input int idle,
                        input int stall, output logic [15:0] xo, output logic [7:0] ro,
                        output logic dz, output int lat);
    int guard;
    repeat (idle) @(posedge clk);
    #1;
    in_valid  = 1'b1;
    z         = zz;
    y         = yy;
    out_ready = (stall == 0);
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    z = 16'($urandom);
    y = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 100) chk("out_valid_timeout", 0, 1);
    xo = x;
    ro = r;
    dz = div_by_zero;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_x", 32'(x), 32'(xo));
      chk("hold_r", 32'(r), 32'(ro));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", 32'(out_valid), 0);
    chk("in_ready_back", 32'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  logic [15:0] zt [5] = '{16'd1000, 16'd65535, 16'd65535, 16'd0, 16'd200};
  logic [7:0]  yt [5] = '{8'd7, 8'd255, 8'd1, 8'd3, 8'd201};
  logic [15:0] xt [5] = '{16'd142, 16'd257, 16'd65535, 16'd0, 16'd0};
  logic [7:0]  rt [5] = '{8'd6, 8'd0, 8'd0, 8'd0, 8'd200};

  initial begin
    logic [15:0] xo;
    logic [7:0]  ro;
    logic        dz;
    int          lat, seen;
    logic [15:0] rz;
    logic [7:0]  ry;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; z = '0; y = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_x", 32'(x), 0);
    chk("rst_r", 32'(r), 0);
    chk("rst_dbz", 32'(div_by_zero), 0);

    for (int i = 0; i < 5; i++) begin
      do_div(zt[i], yt[i], i, 0, xo, ro, dz, lat);
      chk($sformatf("dir%0d_x", i), 32'(xo), 32'(xt[i]));
      chk($sformatf("dir%0d_r", i), 32'(ro), 32'(rt[i]));
      chk($sformatf("dir%0d_dbz", i), 32'(dz), 0);
      chk($sformatf("dir%0d_lat", i), 32'(lat), 17);
    end

    do_div(16'd5, 8'd0, 0, 0, xo, ro, dz, lat);
    chk("dbz_x", 32'(xo), 32'hFFFF);
    chk("dbz_r", 32'(ro), 5);
    chk("dbz_flag", 32'(dz), 1);
    chk("dbz_lat", 32'(lat), 1);

    do_div(16'd1234, 8'd10, 1, 5, xo, ro, dz, lat);
    chk("bp_x", 32'(xo), 123);
    chk("bp_r", 32'(ro), 4);
    chk("bp_dbz", 32'(dz), 0);

    // Reset six cycles into a division
    #1;
    in_valid = 1'b1; z = 16'd40000; y = 8'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_x", 32'(x), 0);
    chk("mid_rst_r", 32'(r), 0);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mid_rst_no_result", 32'(seen), 0);
    do_div(16'd40000, 8'd3, 0, 0, xo, ro, dz, lat);
    chk("after_rst_x", 32'(xo), 13333);
    chk("after_rst_r", 32'(ro), 1);

    for (int i = 0; i < 1500; i++) begin
      rz = 16'($urandom);
      ry = 8'($urandom_range(1, 255));
      do_div(rz, ry, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), xo, ro, dz, lat);
      chk("rnd_identity", 32'(xo) * 32'(ry) + 32'(ro), 32'(rz));
      chk("rnd_r_lt_y", 32'(ro < ry), 1);
      chk("rnd_lat", 32'(lat), 17);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
